crem_cmd_responder: RTL and testbench

CREM_CMD_RESPONDER -- requirements
Module: crem_cmd_responder

---
 rtl/crem_cmd_pkg.sv | 27 ++
 rtl/crem_resp_ser.sv | 52 +++++
 rtl/crem_cmd_responder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_crem_cmd_responder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crem_cmd_pkg.sv
// Shared definitions for the command responder: opcodes, FSM state encoding
// and the ALU function field width.
package crem_cmd_pkg;

  localparam logic [7:0] OP_WR       = 8'hAA;
  localparam logic [7:0] OP_RD       = 8'hBB;
  localparam logic [7:0] OP_ALU      = 8'hCC;
  localparam logic [7:0] OP_ALU_RF01 = 8'hDD;

  localparam int ALU_FUN_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    ALU_A,
    ALU_B,
    ALU_FUN,
    RF_RD,
    RF_RD2,
    ALU_RUN,
    RESP_LO,
    RESP_HI
  } state_e;

endpackage

// File: rtl/crem_resp_ser.sv
// Response byte holder: keeps tx_valid/tx_data steady until the sink accepts,
// and lets the controller queue the next byte or abort the pending one.
module crem_resp_ser #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              accepted
);

  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  assign accepted = tx_valid_q & tx_ready;

  // Next-byte selection: abort beats a new load, a new load beats acceptance.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (abort) begin
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
    end else if (load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = load_data;
    end else if (accepted) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/crem_cmd_responder.sv
// Byte-command responder: decodes write/read/ALU commands into register-file and
// ALU strobes and returns results. Define CREM_CMD_TIMEOUT_EN for the inter-byte timeout.
module crem_cmd_responder
  import crem_cmd_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_err,
  output logic [ADDR_W-1:0]    rf_addr,
  output logic                 rf_wr_en,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic                 rf_rd_en,
  input  logic [DATA_W-1:0]    rf_rd_data,
  input  logic                 rf_rd_valid,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [ALU_FUN_W-1:0] alu_fun,
  output logic                 alu_en,
  input  logic [2*DATA_W-1:0]  alu_out,
  input  logic                 alu_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  if (DATA_W < 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("crem_cmd_responder: DATA_W must be >= 8 and TIMEOUT_CYCLES >= 1");
  end

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     rf_addr_q, rf_addr_d, addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0]     rf_wr_data_q, rf_wr_data_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [DATA_W-1:0]     hi_q, hi_d, ser_byte_s;
  logic [ALU_FUN_W-1:0]  alu_fun_q, alu_fun_d;
  logic                  rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d, alu_en_q, alu_en_d;
  logic                  alu_cmd_q, alu_cmd_d, two_q, two_d;
  logic                  ser_load_s, ser_abort_s, ser_accepted_s, timeout_s;

`ifdef CREM_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Inter-byte idle counter, saturating at the timeout value.
  always_comb begin
    if (rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_s = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_fun_d    = alu_fun_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    alu_cmd_d    = alu_cmd_q;
    two_d        = two_q;
    hi_d         = hi_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    ser_load_s   = 1'b0;
    ser_byte_s   = '0;
    ser_abort_s  = 1'b0;
    if (rx_valid && rx_err) begin
      state_d     = IDLE;
      ser_abort_s = 1'b1;
    end else if (timeout_s && (state_q inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN})) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data[7:0])
              OP_WR:  state_d = WR_ADDR;
              OP_RD:  state_d = RD_ADDR;
              OP_ALU: state_d = ALU_A;
              OP_ALU_RF01: begin
                addr_a_d = '0;
                addr_b_d = ADDR_W'(1);
                state_d  = ALU_FUN;
              end
              default: state_d = IDLE;
            endcase
          end else begin
            state_d = IDLE;
          end
        end
        WR_ADDR: begin
          if (rx_valid) begin
            rf_addr_d = rx_data[ADDR_W-1:0];
            state_d   = WR_DATA;
          end else begin
            state_d = WR_ADDR;
          end
        end
        WR_DATA: begin
          if (rx_valid) begin
            rf_wr_data_d = rx_data;
            rf_wr_en_d   = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = WR_DATA;
          end
        end
        RD_ADDR: begin
          if (rx_valid) begin
            rf_addr_d  = rx_data[ADDR_W-1:0];
            rf_rd_en_d = 1'b1;
            alu_cmd_d  = 1'b0;
            state_d    = RF_RD;
          end else begin
            state_d = RD_ADDR;
          end
        end
        ALU_A: begin
          if (rx_valid) begin
            addr_a_d = rx_data[ADDR_W-1:0];
            state_d  = ALU_B;
          end else begin
            state_d = ALU_A;
          end
        end
        ALU_B: begin
          if (rx_valid) begin
            addr_b_d = rx_data[ADDR_W-1:0];
            state_d  = ALU_FUN;
          end else begin
            state_d = ALU_B;
          end
        end
        ALU_FUN: begin
          if (rx_valid) begin
            alu_fun_d  = rx_data[ALU_FUN_W-1:0];
            rf_addr_d  = addr_a_q;
            rf_rd_en_d = 1'b1;
            alu_cmd_d  = 1'b1;
            state_d    = RF_RD;
          end else begin
            state_d = ALU_FUN;
          end
        end
        // From here on incoming bytes are dropped until the response is out.
        RF_RD: begin
          if (rf_rd_valid && alu_cmd_q) begin
            alu_a_d    = rf_rd_data;
            rf_addr_d  = addr_b_q;
            rf_rd_en_d = 1'b1;
            state_d    = RF_RD2;
          end else if (rf_rd_valid) begin
            ser_load_s = 1'b1;
            ser_byte_s = rf_rd_data;
            two_d      = 1'b0;
            state_d    = RESP_LO;
          end else begin
            state_d = RF_RD;
          end
        end
        RF_RD2: begin
          if (rf_rd_valid) begin
            alu_b_d  = rf_rd_data;
            alu_en_d = 1'b1;
            state_d  = ALU_RUN;
          end else begin
            state_d = RF_RD2;
          end
        end
        ALU_RUN: begin
          if (alu_valid) begin
            ser_load_s = 1'b1;
            ser_byte_s = alu_out[DATA_W-1:0];
            hi_d       = alu_out[2*DATA_W-1:DATA_W];
            two_d      = 1'b1;
            state_d    = RESP_LO;
          end else begin
            state_d = ALU_RUN;
          end
        end
        RESP_LO: begin
          if (ser_accepted_s && two_q) begin
            ser_load_s = 1'b1;
            ser_byte_s = hi_q;
            state_d    = RESP_HI;
          end else if (ser_accepted_s) begin
            state_d = IDLE;
          end else begin
            state_d = RESP_LO;
          end
        end
        RESP_HI: begin
          if (ser_accepted_s) state_d = IDLE;
          else                state_d = RESP_HI;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_fun_q    <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      alu_cmd_q    <= 1'b0;
      two_q        <= 1'b0;
      hi_q         <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_fun_q    <= alu_fun_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      alu_cmd_q    <= alu_cmd_d;
      two_q        <= two_d;
      hi_q         <= hi_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_en_q     <= alu_en_d;
    end
  end

  crem_resp_ser #(.DATA_W(DATA_W)) u_resp_ser (
    .clk       (clk),
    .rst       (rst),
    .abort     (ser_abort_s),
    .load      (ser_load_s),
    .load_data (ser_byte_s),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .accepted  (ser_accepted_s)
  );

  assign rf_addr    = rf_addr_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_data = rf_wr_data_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_fun    = alu_fun_q;
  assign alu_en     = alu_en_q;

endmodule

// File: tb/tb_crem_cmd_responder.sv
// Directed self-checking bench for crem_cmd_responder with simple register-file,
// ALU and TX-sink responders.
module tb_crem_cmd_responder;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int TIMEOUT_CYCLES = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DATA_W-1:0]   rx_data = '0;
  logic                rx_valid = 1'b0, rx_err = 1'b0;
  logic [ADDR_W-1:0]   rf_addr;
  logic                rf_wr_en, rf_rd_en, alu_en, tx_valid;
  logic [DATA_W-1:0]   rf_wr_data, alu_a, alu_b, tx_data;
  logic [DATA_W-1:0]   rf_rd_data = '0;
  logic                rf_rd_valid = 1'b0, alu_valid = 1'b0, tx_ready = 1'b0;
  logic [3:0]          alu_fun;
  logic [2*DATA_W-1:0] alu_out = '0;

  always #5 clk = ~clk;

  crem_cmd_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_valid(alu_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  int errors = 0, checks = 0;
  logic [DATA_W-1:0]   rf_mem [16];
  logic [2*DATA_W-1:0] alu_resp = '0;
  logic [DATA_W-1:0]   tx_log [$];
  logic [ADDR_W-1:0]   rd_log [$];
  logic [DATA_W-1:0]   cap_a = '0, cap_b = '0, held = '0;
  logic [3:0]          cap_fun = '0;
  logic [ADDR_W-1:0]   rd_addr = '0;
  int wr_cnt = 0, alu_pulses = 0, overlap_cnt = 0, unstable_cnt = 0;
  int ready_delay = 0, wait_n = 0, max_wait = 0, rd_cnt = 0, alu_cnt = 0;

  // Edge monitors: register-file writes, strobe overlap, accepted TX bytes.
  always @(posedge clk) begin
    if (rf_wr_en) begin
      wr_cnt++;
      rf_mem[rf_addr] = rf_wr_data;
    end
    if ((int'(rf_wr_en) + int'(rf_rd_en) + int'(alu_en)) > 1) overlap_cnt++;
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
  end

  // Register-file responder: data returns two cycles after rf_rd_en.
  always @(posedge clk) begin
    #1;
    rf_rd_valid = 1'b0;
    if (rd_cnt == 1) begin
      rf_rd_valid = 1'b1;
      rf_rd_data  = rf_mem[rd_addr];
      rd_log.push_back(rd_addr);
    end
    if (rd_cnt != 0) rd_cnt--;
    if (rf_rd_en) begin
      rd_addr = rf_addr;
      rd_cnt  = 2;
    end
  end

  // ALU responder: result returns two cycles after alu_en.
  always @(posedge clk) begin
    #1;
    alu_valid = 1'b0;
    if (alu_cnt == 1) begin
      alu_valid = 1'b1;
      alu_out   = alu_resp;
    end
    if (alu_cnt != 0) alu_cnt--;
    if (alu_en) begin
      cap_a = alu_a; cap_b = alu_b; cap_fun = alu_fun;
      alu_cnt = 2;
      alu_pulses++;
    end
  end

  // TX sink: keeps tx_ready low for ready_delay cycles of each byte and watches stability.
  always @(posedge clk) begin
    #1;
    if (tx_valid && !tx_ready) begin
      if (wait_n == 0) held = tx_data;
      else if (tx_data !== held) unstable_cnt++;
      if (wait_n >= ready_delay) begin
        tx_ready = 1'b1;
        if (wait_n > max_wait) max_wait = wait_n;
      end else begin
        wait_n++;
      end
    end else begin
      tx_ready = 1'b0;
      wait_n   = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; rx_err = err;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 80 && tx_log.size() < n; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (tx_log.size() != n) begin
      errors++; $display("FAIL tx_count: got %0d bytes, expected %0d", tx_log.size(), n);
    end
  endtask

  task automatic clear_logs();
    tx_log.delete(); rd_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({rf_addr, rf_wr_data, alu_a, alu_b, alu_fun, tx_data} !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {rf_addr, rf_wr_data, alu_a, alu_b, alu_fun, tx_data});
    end
    checks++;
    if ({rf_wr_en, rf_rd_en, alu_en, tx_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000", {rf_wr_en, rf_rd_en, alu_en, tx_valid});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    int w0;
    w0 = wr_cnt;
    send_byte(8'hAA, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h26, 1'b0);
    checks++;
    if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h5, 8'h26}) begin
      errors++; $display("FAIL write_pulse: got en=%b addr=%h data=%h expected 1/5/26", rf_wr_en, rf_addr, rf_wr_data);
    end
    idle(1);
    checks++;
    if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL write_one_cycle: got %b expected 0", rf_wr_en); end
    idle(5);
    checks++;
    if (wr_cnt - w0 != 1 || tx_log.size() != 0) begin
      errors++; $display("FAIL write_no_tx: got writes=%0d tx=%0d expected 1/0", wr_cnt - w0, tx_log.size());
    end
    send_byte(8'hAA, 1'b0); send_byte(8'hF3, 1'b0); send_byte(8'h11, 1'b0);
    checks++;
    if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h3, 8'h11}) begin
      errors++; $display("FAIL write_addr_mask: got en=%b addr=%h data=%h expected 1/3/11", rf_wr_en, rf_addr, rf_wr_data);
    end
    idle(2);
  endtask

  task automatic test_read();
    clear_logs(); ready_delay = 3; max_wait = 0; unstable_cnt = 0;
    send_byte(8'hBB, 1'b0); send_byte(8'h05, 1'b0);
    checks++;
    if ({rf_rd_en, rf_addr} !== {1'b1, 4'h5}) begin
      errors++; $display("FAIL read_strobe: got en=%b addr=%h expected 1/5", rf_rd_en, rf_addr);
    end
    wait_tx(1);
    checks++;
    if (tx_log[0] !== 8'h26) begin errors++; $display("FAIL read_data: got %h expected 26", tx_log[0]); end
    checks++;
    if (max_wait != 3 || unstable_cnt != 0) begin
      errors++; $display("FAIL read_hold: got wait=%0d unstable=%0d expected 3/0", max_wait, unstable_cnt);
    end
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL read_done: got tx_valid=%b expected 0", tx_valid); end
    ready_delay = 0;
    idle(2);
  endtask

  task automatic test_alu_cc();
    clear_logs();
    rf_mem[7] = 8'h31; alu_resp = 16'h0057;
    send_byte(8'hCC, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h07, 1'b0); send_byte(8'h00, 1'b0);
    wait_tx(2);
    checks++;
    if ({cap_a, cap_b, cap_fun} !== {8'h26, 8'h31, 4'h0}) begin
      errors++; $display("FAIL cc_operands: got a=%h b=%h fun=%h expected 26/31/0", cap_a, cap_b, cap_fun);
    end
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== 4'h5 || rd_log[1] !== 4'h7) begin
      errors++; $display("FAIL cc_read_order: got n=%0d %h %h expected 2 5 7", rd_log.size(), rd_log[0], rd_log[1]);
    end
    checks++;
    if (tx_log[0] !== 8'h57 || tx_log[1] !== 8'h00) begin
      errors++; $display("FAIL cc_response: got %h %h expected 57 00", tx_log[0], tx_log[1]);
    end
    idle(2);
  endtask

  task automatic test_alu_dd();
    clear_logs();
    rf_mem[0] = 8'h03; rf_mem[1] = 8'h01; alu_resp = 16'h0002;
    send_byte(8'hDD, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    wait_tx(2);
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== 4'h0 || rd_log[1] !== 4'h1) begin
      errors++; $display("FAIL dd_read_order: got n=%0d %h %h expected 2 0 1", rd_log.size(), rd_log[0], rd_log[1]);
    end
    checks++;
    if ({cap_a, cap_b, cap_fun} !== {8'h03, 8'h01, 4'h1}) begin
      errors++; $display("FAIL dd_operands: got a=%h b=%h fun=%h expected 03/01/1", cap_a, cap_b, cap_fun);
    end
    checks++;
    if (tx_log[0] !== 8'h02 || tx_log[1] !== 8'h00) begin
      errors++; $display("FAIL dd_response: got %h %h expected 02 00", tx_log[0], tx_log[1]);
    end
    clear_logs();
    send_byte(8'hBB, 1'b0); send_byte(8'h01, 1'b0);
    wait_tx(1);
    checks++;
    if (tx_log[0] !== 8'h01) begin errors++; $display("FAIL dd_ignored_byte: got %h expected 01", tx_log[0]); end
    idle(2);
  endtask

  task automatic test_errors();
    int w0;
    clear_logs(); w0 = wr_cnt;
    send_byte(8'hAA, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h77, 1'b1);
    idle(4);
    checks++;
    if (wr_cnt != w0) begin errors++; $display("FAIL err_no_write: got %0d writes expected 0", wr_cnt - w0); end
    send_byte(8'hAA, 1'b1); send_byte(8'h05, 1'b0); send_byte(8'h26, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'hAA - 8'h01, 1'b0);
    idle(6);
    checks++;
    if (wr_cnt != w0 || rd_log.size() != 0 || tx_log.size() != 0) begin
      errors++; $display("FAIL bad_opcode_dropped: got wr=%0d rd=%0d tx=%0d expected 0/0/0", wr_cnt - w0, rd_log.size(), tx_log.size());
    end
    send_byte(8'hBB, 1'b0); send_byte(8'h05, 1'b0);
    wait_tx(1);
    checks++;
    if (tx_log[0] !== 8'h26) begin errors++; $display("FAIL err_then_read: got %h expected 26", tx_log[0]); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int w0;
    clear_logs(); ready_delay = 10;
    send_byte(8'hBB, 1'b0); send_byte(8'h05, 1'b0);
    for (int i = 0; i < 20 && !tx_valid; i++) idle(1);
    rst = 1'b1;
    idle(1);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_resp: got tx_valid=%b expected 0", tx_valid); end
    rst = 1'b0; ready_delay = 0;
    idle(6);
    checks++;
    if (tx_log.size() != 0) begin errors++; $display("FAIL reset_discard: got %0d bytes expected 0", tx_log.size()); end
    w0 = wr_cnt;
    send_byte(8'hAA, 1'b0); send_byte(8'h05, 1'b0);
    rst = 1'b1; idle(1); rst = 1'b0;
    send_byte(8'hBB, 1'b0); send_byte(8'h05, 1'b0);
    wait_tx(1);
    checks++;
    if (tx_log[0] !== 8'h26 || wr_cnt != w0) begin
      errors++; $display("FAIL reset_mid_cmd: got %h writes=%0d expected 26/0", tx_log[0], wr_cnt - w0);
    end
    idle(2);
  endtask

  task automatic test_timeout();
    clear_logs();
    send_byte(8'hBB, 1'b0);
    idle(TIMEOUT_CYCLES + 20);
    send_byte(8'h05, 1'b0);
`ifdef CREM_CMD_TIMEOUT_EN
    idle(8);
    checks++;
    if (rd_log.size() != 0 || tx_log.size() != 0) begin
      errors++; $display("FAIL timeout_idle: got rd=%0d tx=%0d expected 0/0", rd_log.size(), tx_log.size());
    end
`else
    checks++;
    if (rf_rd_en !== 1'b1) begin errors++; $display("FAIL no_timeout_wait: got rd_en=%b expected 1", rf_rd_en); end
    wait_tx(1);
`endif
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_alu_cc();
    test_alu_dd();
    test_errors();
    test_reset_mid();
    test_timeout();
    checks++;
    if (overlap_cnt != 0 || alu_pulses != 2) begin
      errors++; $display("FAIL strobes: got overlap=%0d alu_pulses=%0d expected 0/2", overlap_cnt, alu_pulses);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
